// File: rtl/fip_pkg.sv
// fip_pkg -- shared Q16.16 fixed-point types and constants for the divider scheduler.
//   fip_t      : signed Q16.16 word
//   FIP_MIN/MAX: saturation limits used for divide-by-zero results
//   div_tag_t  : one delay-line stage {valid, tag, dz, xsign}
package fip_pkg;

  typedef logic signed [31:0] fip_t;

  localparam fip_t FIP_MAX = 32'sh7FFF_FFFF;
  localparam fip_t FIP_MIN = 32'sh8000_0000;

  // Wide enough for the largest supported requester count (8).
  localparam int TAG_W = 3;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic             dz;
    logic             xsign;
  } div_tag_t;

endpackage

// File: rtl/fip_rr_arbiter.sv
// fip_rr_arbiter -- round-robin grant among N requesters.
//   i_clk, i_rst : clock, async active-high reset
//   req          : request vector
//   gnt          : one-hot grant (never without req, forced low in reset)
//   gnt_idx      : index of the granted requester
//   gnt_any      : a grant is issued this cycle
// The first request at or after the pointer wins; the pointer moves past the
// winner and holds when nothing is granted.
module fip_rr_arbiter #(
  parameter int N  = 3,
  parameter int IW = $clog2(N)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_any
);

  logic [IW-1:0] ptr;
  logic [N-1:0]  req_m;
  int            c;

  assign req_m = i_rst ? '0 : req;

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    c       = 0;
    for (int o = 0; o < N; o++) begin
      c = (int'(ptr) + o) % N;
      if (!gnt_any && req_m[c]) begin
        gnt_any = 1'b1;
        gnt_idx = IW'(c);
      end
    end
    gnt = '0;
    if (gnt_any) gnt[gnt_idx] = 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)        ptr <= '0;
    else if (gnt_any) ptr <= (int'(gnt_idx) == N-1) ? '0 : gnt_idx + 1'b1;
  end

endmodule

// File: rtl/fip_32_div_sched.sv
// fip_32_div_sched -- shares one pipelined Q16.16 divider among N_REQ requesters.
//   i_clk, i_rst          : clock, async active-high reset
//   i_req_valid/x/y       : per-requester operands (x numerator, y denominator)
//   o_req_ready           : one-hot grant, transfer = valid & ready
//   o_div_x/o_div_y       : registered operands to the divider
//   i_div_z               : divider quotient, DIV_LAT cycles after operands
//   o_rsp_valid/z/dz      : one-hot response, shared quotient bus, div-by-zero flag
//   o_busy                : any divide in flight
// Optional feature macro FIP_DIV_ZERO_SAT_EN: y==0 returns FIP_MAX/FIP_MIN by
// numerator sign with o_rsp_dz=1 instead of the divider's result.
module fip_32_div_sched
  import fip_pkg::*;
#(
  parameter int N_REQ   = 3,
  parameter int DIV_LAT = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [N_REQ-1:0]       i_req_valid,
  input  logic [N_REQ-1:0][31:0] i_req_x,
  input  logic [N_REQ-1:0][31:0] i_req_y,
  output logic [N_REQ-1:0]       o_req_ready,
  output logic [31:0]            o_div_x,
  output logic [31:0]            o_div_y,
  input  logic [31:0]            i_div_z,
  output logic [N_REQ-1:0]       o_rsp_valid,
  output logic [31:0]            o_rsp_z,
  output logic                   o_rsp_dz,
  output logic                   o_busy
);

  localparam int IW = $clog2(N_REQ);

  logic [IW-1:0] gnt_idx;
  logic          gnt_any;
  div_tag_t      new_tag;
  div_tag_t      head;
  div_tag_t      dly [DIV_LAT:0];

  fip_rr_arbiter #(.N(N_REQ), .IW(IW)) u_arb (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .req     (i_req_valid),
    .gnt     (o_req_ready),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  // Operands hold their last value across bubbles; the delay line marks
  // which divider outputs matter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_div_x <= '0;
      o_div_y <= '0;
    end else if (gnt_any) begin
      o_div_x <= i_req_x[gnt_idx];
      o_div_y <= i_req_y[gnt_idx];
    end
  end

  always_comb begin
    new_tag       = '0;
    new_tag.valid = gnt_any;
    new_tag.tag   = TAG_W'(gnt_idx);
`ifdef FIP_DIV_ZERO_SAT_EN
    new_tag.dz    = gnt_any && (i_req_y[gnt_idx] == '0);
    new_tag.xsign = i_req_x[gnt_idx][31];
`endif
  end

  // Stage 0 lines up with the operand registers, stage DIV_LAT with i_div_z.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i <= DIV_LAT; i++) dly[i] <= '0;
    end else begin
      dly[0] <= new_tag;
      for (int i = 1; i <= DIV_LAT; i++) dly[i] <= dly[i-1];
    end
  end

  assign head = dly[DIV_LAT];

  for (genvar k = 0; k < N_REQ; k++) begin : g_rsp
    assign o_rsp_valid[k] = head.valid && (head.tag == TAG_W'(k));
  end

`ifdef FIP_DIV_ZERO_SAT_EN
  assign o_rsp_dz = head.valid & head.dz;
  assign o_rsp_z  = !head.valid ? '0 :
                    head.dz     ? (head.xsign ? FIP_MIN : FIP_MAX) : i_div_z;
`else
  logic unused_dz_bits;
  assign unused_dz_bits = ^{head.dz, head.xsign};
  assign o_rsp_dz       = 1'b0;
  assign o_rsp_z        = head.valid ? i_div_z : '0;
`endif

  always_comb begin
    o_busy = 1'b0;
    for (int i = 0; i <= DIV_LAT; i++) o_busy |= dly[i].valid;
  end

endmodule
